reg_rd_scan: RTL and testbench

- Read-back responder for the 8-bit config register bank; the opposite direction of the register write path.
- On a host request, it takes a coherent snapshot of the flat register bank.
- It then streams a contiguous range of bytes back over a valid/ready byte stream.
- Sits between the register bank outputs and the host/debug read channel of the deparser config block.

---
 rtl/reg_rd_scan_pkg.sv | 33 +++
 rtl/reg_rd_scan.sv | 118 +++++++++++
 tb/tb_reg_rd_scan.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_rd_scan_pkg.sv
// rtl/reg_rd_scan_pkg.sv - shared types and helpers for the register read-back scanner
package reg_rd_scan_pkg;

    localparam int unsigned REG_W      = 8;
    localparam int unsigned MAX_REG    = 256;
    localparam int unsigned MAX_BANK_W = MAX_REG * REG_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // A request is legal when it reads at least one register and stays inside the bank.
    // The sum is formed in 32 bits, so it cannot wrap for any address/length port width.
    function automatic logic legal_req(
        input int unsigned addr,
        input int unsigned len,
        input int unsigned num_reg
    );
        return (len != 0) && ((addr + len) <= num_reg);
    endfunction

    // Pick register k out of a flat bank (reg k lives at bits [8k+7:8k]).
    function automatic logic [REG_W-1:0] byte_sel(
        input logic [MAX_BANK_W-1:0] bank,
        input logic [7:0]            k
    );
        logic [10:0] lsb;
        lsb = {k, 3'b000};
        return bank[lsb +: REG_W];
    endfunction

endpackage

// File: rtl/reg_rd_scan.sv
// rtl/reg_rd_scan.sv - snapshot a register bank on request and stream a byte range back
module reg_rd_scan
    import reg_rd_scan_pkg::*;
#(
    parameter int unsigned NUM_REG = 16,
    parameter int unsigned AW      = $clog2(NUM_REG)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req,
    input  logic [AW-1:0]            i_addr,
    input  logic [AW:0]              i_len,
    output logic                     o_req_rdy,
    input  logic [NUM_REG*REG_W-1:0] i_reg_bank,
    output logic [REG_W-1:0]         o_dat,
    output logic                     o_vld,
    input  logic                     i_rdy,
    output logic                     o_last,
    output logic                     o_err,
    output logic                     o_busy
);

    localparam logic [AW:0] REM_ONE = (AW+1)'(1);
    localparam logic [AW:0] REM_TWO = (AW+1)'(2);

    state_t                     state_q, state_d;
    logic [NUM_REG*REG_W-1:0]   snap_q, snap_d;
    logic [MAX_BANK_W-1:0]      snap_ext;
    logic [AW-1:0]              idx_q, idx_d, idx_inc;
    logic [AW:0]                rem_q, rem_d;
    logic [REG_W-1:0]           dat_q, dat_d;
    logic                       vld_q, vld_d;
    logic                       last_q, last_d;
    logic                       err_q, err_d;
    logic                       req_legal;

    assign snap_ext  = MAX_BANK_W'(snap_q);
    assign idx_inc   = idx_q + 1'b1;
    assign req_legal = legal_req(32'(i_addr), 32'(i_len), NUM_REG);

    // Next-state and next-output decisions; the first byte of a burst is loaded one cycle
    // after acceptance (vld_q still low in SEND), later bytes are loaded on each accepted beat.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        dat_d   = dat_q;
        vld_d   = vld_q;
        last_d  = last_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req) begin
                    if (req_legal) begin
                        snap_d  = i_reg_bank;
                        idx_d   = i_addr;
                        rem_d   = i_len;
                        state_d = SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (!vld_q) begin
                    dat_d  = byte_sel(snap_ext, 8'(idx_q));
                    vld_d  = 1'b1;
                    last_d = (rem_q == REM_ONE);
                end else if (i_rdy) begin
                    if (rem_q == REM_ONE) begin
                        // Final beat taken: idx is left on the last register, never past it.
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d  = idx_inc;
                        rem_d  = rem_q - 1'b1;
                        dat_d  = byte_sel(snap_ext, 8'(idx_inc));
                        last_d = (rem_q == REM_TWO);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, snapshot, counters and output register; reset wins over any request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            dat_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign o_dat     = dat_q;
    assign o_vld     = vld_q;
    assign o_last    = last_q;
    assign o_err     = err_q;
    assign o_req_rdy = (state_q == IDLE);
    assign o_busy    = (state_q == SEND);

endmodule

// File: tb/tb_reg_rd_scan.sv
// tb/tb_reg_rd_scan.sv - directed self-checking bench for reg_rd_scan
module tb_reg_rd_scan;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_req;
    logic [3:0]   i_addr;
    logic [4:0]   i_len;
    logic         o_req_rdy;
    logic [127:0] i_reg_bank;
    logic [7:0]   o_dat;
    logic         o_vld;
    logic         i_rdy;
    logic         o_last;
    logic         o_err;
    logic         o_busy;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    reg_rd_scan #(.NUM_REG(16), .AW(4)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_len      (i_len),
        .o_req_rdy  (o_req_rdy),
        .i_reg_bank (i_reg_bank),
        .o_dat      (o_dat),
        .o_vld      (o_vld),
        .i_rdy      (i_rdy),
        .o_last     (o_last),
        .o_err      (o_err),
        .o_busy     (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic l);
        chk({tag, "_vld"},  32'(o_vld),  32'd1);
        chk({tag, "_dat"},  32'(o_dat),  32'(d));
        chk({tag, "_last"}, 32'(o_last), 32'(l));
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_vld"},  32'(o_vld),     32'd0);
        chk({tag, "_last"}, 32'(o_last),    32'd0);
        chk({tag, "_rdy"},  32'(o_req_rdy), 32'd1);
        chk({tag, "_busy"}, 32'(o_busy),    32'd0);
    endtask

    task automatic fill_bank;
        for (int k = 0; k < 16; k++) i_reg_bank[k*8 +: 8] = 8'(8'h10 + k);
    endtask

    // Present a request across one clock edge, then drop it.
    task automatic req(input logic [3:0] a, input logic [4:0] l);
        i_req  = 1'b1;
        i_addr = a;
        i_len  = l;
        step();
        i_req  = 1'b0;
    endtask

    initial begin
        logic [7:0] t3_dat [5];
        logic       t3_last[5];
        logic       t3_rdy [5];
        t3_dat  = '{8'h12, 8'h13, 8'h13, 8'h13, 8'h14};
        t3_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        t3_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        fill_bank();
        i_rst  = 1'b1;
        i_req  = 1'b1;
        i_addr = 4'd0;
        i_len  = 5'd1;
        i_rdy  = 1'b1;

        // 1: reset with a request pending
        for (int c = 0; c < 3; c++) begin
            step();
            idle_chk("rst");
            chk("rst_err", 32'(o_err), 32'd0);
            chk("rst_dat", 32'(o_dat), 32'd0);
        end
        i_rst = 1'b0;
        i_req = 1'b0;
        step();
        idle_chk("post_rst0");
        step();
        idle_chk("post_rst1");

        // 2: addr 2 len 3, sink always ready
        chk("t2_rdy_before", 32'(o_req_rdy), 32'd1);
        req(4'd2, 5'd3);
        chk("t2_T_vld",  32'(o_vld),     32'd0);
        chk("t2_T_busy", 32'(o_busy),    32'd1);
        chk("t2_T_rdy",  32'(o_req_rdy), 32'd0);
        step();
        beat("t2_b0", 8'h12, 1'b0);
        step();
        beat("t2_b1", 8'h13, 1'b0);
        chk("t2_b1_rdy", 32'(o_req_rdy), 32'd0);
        step();
        beat("t2_b2", 8'h14, 1'b1);
        step();
        idle_chk("t2_end");

        // 3: same request with back-pressure 1,0,0,1,1
        req(4'd2, 5'd3);
        step();
        for (int i = 0; i < 5; i++) begin
            i_rdy = t3_rdy[i];
            beat($sformatf("t3_c%0d", i), t3_dat[i], t3_last[i]);
            step();
        end
        i_rdy = 1'b1;
        idle_chk("t3_end");

        // 4: bank changes after acceptance do not reach the burst
        req(4'd0, 5'd2);
        i_reg_bank[7:0]  = 8'hAA;
        i_reg_bank[15:8] = 8'h55;
        step();
        beat("t4_b0", 8'h10, 1'b0);
        step();
        beat("t4_b1", 8'h11, 1'b1);
        step();
        idle_chk("t4_end");
        fill_bank();

        // 5a: addr 14 len 3 overruns the bank
        req(4'd14, 5'd3);
        chk("t5a_err", 32'(o_err), 32'd1);
        idle_chk("t5a");
        step();
        chk("t5a_err_clr", 32'(o_err), 32'd0);
        idle_chk("t5a_after");

        // 5b: zero length
        req(4'd3, 5'd0);
        chk("t5b_err", 32'(o_err), 32'd1);
        idle_chk("t5b");
        step();
        chk("t5b_err_clr", 32'(o_err), 32'd0);

        // 5c: last register, single beat
        req(4'd15, 5'd1);
        chk("t5c_err", 32'(o_err), 32'd0);
        chk("t5c_T_vld", 32'(o_vld), 32'd0);
        step();
        beat("t5c_b0", 8'h1F, 1'b1);
        step();
        idle_chk("t5c_end");

        // 5d: whole bank
        req(4'd0, 5'd16);
        chk("t5d_err", 32'(o_err), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step();
            beat($sformatf("t5d_b%0d", i), 8'(8'h10 + i), (i == 15));
        end
        step();
        idle_chk("t5d_end");

        // 6: request during SEND ignored, then reset mid-burst, then a clean request
        i_rdy = 1'b0;
        req(4'd0, 5'd4);
        step();
        beat("t6_b0", 8'h10, 1'b0);
        i_req  = 1'b1;
        i_addr = 4'd14;
        i_len  = 5'd3;
        step();
        beat("t6_hold0", 8'h10, 1'b0);
        chk("t6_hold0_err", 32'(o_err),     32'd0);
        chk("t6_hold0_rdy", 32'(o_req_rdy), 32'd0);
        i_addr = 4'd5;
        i_len  = 5'd2;
        step();
        beat("t6_hold1", 8'h10, 1'b0);
        chk("t6_hold1_err", 32'(o_err), 32'd0);
        i_req = 1'b0;
        i_rdy = 1'b1;
        step();
        beat("t6_b1", 8'h11, 1'b0);
        i_rdy = 1'b0;
        i_rst = 1'b1;
        step();
        idle_chk("t6_rst");
        chk("t6_rst_dat", 32'(o_dat), 32'd0);
        i_rst = 1'b0;
        step();
        idle_chk("t6_post_rst");
        i_rdy = 1'b1;
        req(4'd7, 5'd2);
        step();
        beat("t6_n0", 8'h17, 1'b0);
        step();
        beat("t6_n1", 8'h18, 1'b1);
        step();
        idle_chk("t6_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
